// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction timer game controller (optional best score: BEST_SCORE_EN)
module reaction_timer_core #(
  parameter int CLK_HZ          = 10_000_000,
  parameter int MIN_DELAY_MS    = 1000,
  parameter int DELAY_RAND_BITS = 11,
  parameter int MAX_MS          = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic        led_go,
  output logic [13:0] value,
  output logic        show_error,
  output logic [13:0] best_ms
);

  localparam int          DIV      = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int          PRESC_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [11:0] MIN_DLY  = 12'(MIN_DELAY_MS);
  localparam logic [13:0] MAX_VAL  = 14'(MAX_MS);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           start_sync_q, react_sync_q;
  logic                 start_prev_q, react_prev_q;
  logic                 start_evt_q, react_evt_q;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 ms_tick;
  logic [11:0]          delay_q, delay_d;
  logic [11:0]          rand_ms;
  logic [13:0]          value_q, value_d;
  logic                 led_go_q, led_go_d;
  logic                 show_error_q, show_error_d;
  logic                 react_hit;

  // Two-flop synchronizers plus registered rising-edge pulses for both buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= 2'b00;
      react_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      react_prev_q <= 1'b0;
      start_evt_q  <= 1'b0;
      react_evt_q  <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], btn_start};
      react_sync_q <= {react_sync_q[0], btn_react};
      start_prev_q <= start_sync_q[1];
      react_prev_q <= react_sync_q[1];
      start_evt_q  <= start_sync_q[1] & ~start_prev_q;
      react_evt_q  <= react_sync_q[1] & ~react_prev_q;
    end
  end

  // Galois LFSR free-runs every cycle; the nonzero seed keeps it out of the lock-up state
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // Random part of the wait is the low LFSR bits, zero-extended to the delay width
  always_comb begin
    rand_ms = 12'd0;
    rand_ms[DELAY_RAND_BITS-1:0] = lfsr_q[DELAY_RAND_BITS-1:0];
  end

  // Millisecond prescaler restarts on every state change so each state sees full ms periods
  always_comb begin
    ms_tick = (presc_q == PRESC_LAST);
    if (state_d != state_q) begin
      presc_d = '0;
    end else if (ms_tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Game sequencing: react events take priority over delay expiry and ms ticks
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    value_d   = value_q;
    react_hit = 1'b0;
    case (state_q)
      S_IDLE, S_RESULT, S_ERROR: begin
        if (start_evt_q) begin
          state_d = S_WAIT;
          delay_d = MIN_DLY + rand_ms;
        end
      end
      S_WAIT: begin
        if (react_evt_q) begin
          state_d = S_ERROR;
        end else if (delay_q == 12'd0) begin
          state_d = S_GO;
          value_d = 14'd0;
        end else if (ms_tick) begin
          delay_d = delay_q - 12'd1;
        end
      end
      S_GO: begin
        if (react_evt_q) begin
          state_d   = S_RESULT;
          react_hit = 1'b1;
        end else if (value_q == MAX_VAL) begin
          state_d = S_RESULT;
        end else if (ms_tick) begin
          value_d = value_q + 14'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    led_go_d     = (state_d == S_GO);
    show_error_d = (state_d == S_ERROR);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      presc_q      <= '0;
      delay_q      <= 12'd0;
      value_q      <= 14'd0;
      led_go_q     <= 1'b0;
      show_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      presc_q      <= presc_d;
      delay_q      <= delay_d;
      value_q      <= value_d;
      led_go_q     <= led_go_d;
      show_error_q <= show_error_d;
    end
  end

  assign led_go     = led_go_q;
  assign value      = value_q;
  assign show_error = show_error_q;

`ifdef BEST_SCORE_EN
  logic [13:0] best_q, best_d;

  // Only react-terminated rounds compete; zero means no score recorded yet
  always_comb begin
    best_d = best_q;
    if (react_hit && ((best_q == 14'd0) || (value_q < best_q))) begin
      best_d = value_q;
    end
  end

  // Best score survives rounds and is cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= 14'd0;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms = best_q;
`else
  logic unused_react_hit;
  assign unused_react_hit = react_hit;
  assign best_ms          = 14'd0;
`endif

endmodule
